// File: rtl/text_write_ctrl.sv
// Text-mode write controller: turns a byte stream into text-RAM cell writes,
// tracks the cursor, and handles LF/CR/BS/FF plus row clearing on wrap.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module text_write_ctrl #(
    parameter int unsigned COLS      = 70,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic [11:0] cursor_pos,
    output logic        cursor_vis
);

    localparam int unsigned AW    = 12;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT,
        S_CLR_ROW,
        S_CLR_ALL
    } state_t;

    state_t          r_state;
    logic [7:0]      r_byte;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [AW-1:0]   r_pos;
    logic            r_ready;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_data;
    logic            r_wren;
    logic [AW-1:0]   r_clr_addr;
    logic [AW-1:0]   r_clr_end;

    logic            w_xfer;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_row_change;
    logic [AW-1:0]   w_row_base;
    logic [AW-1:0]   w_next_base;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Handshake, cursor geometry and next-row base address
    assign w_xfer       = ch_valid && r_ready;
    assign w_last_col   = (r_col == CW'(COLS - 1));
    assign w_last_row   = (r_row == RW'(ROWS - 1));
    assign w_row_change = (is_print(r_byte) && w_last_col) || (r_byte == 8'h0A);
    assign w_row_base   = r_pos - AW'(r_col);
    assign w_next_base  = w_last_row ? '0 : (w_row_base + AW'(COLS));

    // Main controller FSM with registered RAM port, ready and cursor
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_CLR_ALL;
            r_byte     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_pos      <= '0;
            r_ready    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_clr_addr <= '0;
            r_clr_end  <= AW'(CELLS);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wren <= 1'b0;
                    if (w_xfer) begin
                        r_byte  <= ch_data;
                        r_ready <= 1'b0;
                        r_data  <= 8'h00;
                        r_addr  <= r_pos;
                        if (ch_data == 8'h0C) begin
                            // Full clear starts writing address 0 right away
                            r_state    <= S_CLR_ALL;
                            r_wren     <= 1'b1;
                            r_addr     <= '0;
                            r_clr_addr <= AW'(1);
                            r_clr_end  <= AW'(CELLS);
                        end else begin
                            r_state <= S_PUT;
                            if (is_print(ch_data)) begin
                                r_wren <= 1'b1;
                                r_data <= ch_data;
                            end else if ((ch_data == 8'h08) &&
                                         ((r_col != '0) || (r_row != '0))) begin
                                // Backspace: the previous cell is always pos-1
                                r_wren <= 1'b1;
                                r_addr <= r_pos - AW'(1);
                                r_pos  <= r_pos - AW'(1);
                                if (r_col != '0) begin
                                    r_col <= r_col - 1'b1;
                                end else begin
                                    r_col <= CW'(COLS - 1);
                                    r_row <= r_row - 1'b1;
                                end
                            end
                        end
                    end
                end

                S_PUT: begin
                    r_wren <= 1'b0;
                    if (w_row_change) begin
                        // Move to the next row and clear it, first cell now
                        r_col      <= '0;
                        r_row      <= w_last_row ? '0 : (r_row + 1'b1);
                        r_pos      <= w_next_base;
                        r_addr     <= w_next_base;
                        r_data     <= 8'h00;
                        r_wren     <= 1'b1;
                        r_clr_addr <= w_next_base + AW'(1);
                        r_clr_end  <= w_next_base + AW'(COLS);
                        r_state    <= S_CLR_ROW;
                    end else begin
                        if (is_print(r_byte)) begin
                            r_col <= r_col + 1'b1;
                            r_pos <= r_pos + AW'(1);
                        end else if (r_byte == 8'h0D) begin
                            r_col <= '0;
                            r_pos <= w_row_base;
                        end
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_CLR_ROW, S_CLR_ALL: begin
                    if (r_clr_addr == r_clr_end) begin
                        r_wren  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                        if (r_state == S_CLR_ALL) begin
                            r_pos <= '0;
                            r_row <= '0;
                            r_col <= '0;
                        end
                    end else begin
                        r_wren     <= 1'b1;
                        r_addr     <= r_clr_addr;
                        r_data     <= 8'h00;
                        r_clr_addr <= r_clr_addr + AW'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ch_ready   = r_ready;
    assign ram_addr   = r_addr;
    assign ram_data   = r_data;
    assign ram_wren   = r_wren;
    assign cursor_pos = r_pos;

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_vis;
    logic [AW-1:0] r_last_pos;

    // Blink half-period counter, restarted visible on every cursor move
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_vis       <= 1'b1;
            r_last_pos  <= '0;
        end else if (r_pos != r_last_pos) begin
            r_last_pos  <= r_pos;
            r_blink_cnt <= '0;
            r_vis       <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_vis       <= ~r_vis;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign cursor_vis = r_vis;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^BLINK_DIV;
    assign cursor_vis     = 1'b1;
`endif

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl: directed table, corner sequences,
// and random bytes against a screen-level reference model.
module tb_text_write_ctrl;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = CELLS + 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [11:0] cursor_pos;
    logic        cursor_vis;

    always #5 clk = ~clk;

    text_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .cursor_pos (cursor_pos),
        .cursor_vis (cursor_vis)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] dut_ram [CELLS];
    logic [7:0] mdl_ram [CELLS];
    int         mpos;
    int         exp_q[$];
    int         got_q[$];
    int         last_lat;

    // Text RAM attached to the write port
    always @(posedge clk) begin
        if (ram_wren === 1'b1 && int'(ram_addr) < CELLS)
            dut_ram[ram_addr] <= ram_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Screen model: row/col from division, writes listed as addr*256+data
    task automatic model_push(input int a, input int d);
        exp_q.push_back(a * 256 + d);
        mdl_ram[a] = 8'(d);
    endtask

    task automatic model_clear_row(input int r);
        for (int c = 0; c < COLS; c++) model_push(r * COLS + c, 0);
    endtask

    task automatic model(input logic [7:0] b, output int lat);
        int row, col, nr;
        row = mpos / COLS;
        col = mpos % COLS;
        nr  = (row + 1) % ROWS;
        lat = 2;
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_push(mpos, int'(b));
            if (col == COLS - 1) begin
                model_clear_row(nr);
                mpos = nr * COLS;
                lat  = 2 + COLS;
            end else begin
                mpos = mpos + 1;
            end
        end else if (b == 8'h0A) begin
            model_clear_row(nr);
            mpos = nr * COLS;
            lat  = 2 + COLS;
        end else if (b == 8'h0D) begin
            mpos = row * COLS;
        end else if (b == 8'h08) begin
            if (mpos > 0) begin
                mpos = mpos - 1;
                model_push(mpos, 0);
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) model_push(i, 0);
            mpos = 0;
            lat  = 1 + CELLS;
        end
    endtask

    // Offer one byte (called at a negedge), record writes until ready returns
    task automatic send(input logic [7:0] b);
        int n, lat, bad;
        got_q.delete();
        exp_q.delete();
        ch_valid = 1'b1;
        ch_data  = b;
        n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            chk("ready_timeout", 32'(n), 32'(0));
            ch_valid = 1'b0;
            return;
        end
        model(b, lat);
        @(negedge clk);
        ch_valid = 1'b0;
        n = 1;
        while (ch_ready !== 1'b1 && n < LIMIT) begin
            if (ram_wren === 1'b1) got_q.push_back(int'(ram_addr) * 256 + int'(ram_data));
            @(negedge clk);
            n++;
        end
        last_lat = n;
        chk("latency", 32'(n), 32'(lat));
        chk("wren_in_idle", {31'd0, ram_wren}, 32'(0));
        chk("cursor_pos", {20'd0, cursor_pos}, 32'(mpos));
        bad = (got_q.size() == exp_q.size()) ? 0 : 1;
        if (bad == 0)
            for (int i = 0; i < got_q.size(); i++) if (got_q[i] != exp_q[i]) bad++;
        chk("write_seq", 32'(bad), 32'(0));
`ifndef CURSOR_BLINK_EN
        chk("cursor_vis", {31'd0, cursor_vis}, 32'(1));
`endif
    endtask

    // Apply reset for some cycles then check the power-up full clear
    task automatic reset_and_clear(input int cycles, input logic hold_valid);
        int n, bad;
        reset_n  = 1'b0;
        ch_valid = hold_valid;
        ch_data  = 8'h41;
        repeat (cycles) @(negedge clk);
        chk("rst_wren", {31'd0, ram_wren}, 32'(0));
        chk("rst_ready", {31'd0, ch_ready}, 32'(0));
        chk("rst_cursor", {20'd0, cursor_pos}, 32'(0));
        chk("rst_vis", {31'd0, cursor_vis}, 32'(1));
        reset_n  = 1'b1;
        ch_valid = 1'b0;
        n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (ch_ready !== 1'b1)
                if (!(ram_wren === 1'b1 && int'(ram_addr) == n - 1 && ram_data === 8'h00)) bad++;
        end while (ch_ready !== 1'b1 && n < LIMIT);
        chk("clr_latency", 32'(n), 32'(CELLS + 1));
        chk("clr_seq", 32'(bad), 32'(0));
        chk("clr_cursor", {20'd0, cursor_pos}, 32'(0));
        for (int i = 0; i < CELLS; i++) mdl_ram[i] = 8'h00;
        mpos = 0;
    endtask

    typedef struct {
        logic [7:0] ch;
        int         pos;
        int         lat;
        int         nw;
        int         a0;
        int         d0;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n, w1, w2, w3, lat, bad, ffs;
        logic [7:0] b;
        reset_n  = 1'b0;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        mpos     = 0;
        for (int i = 0; i < CELLS; i++) begin
            dut_ram[i] = 8'h00;
            mdl_ram[i] = 8'h00;
        end
        @(negedge clk);

        reset_and_clear(3, 1'b0);

        // Directed table from a freshly cleared screen, cursor at 0
        tbl[0]  = '{8'h41, 1,  2,        1,  0,  8'h41};
        tbl[1]  = '{8'h42, 2,  2,        1,  1,  8'h42};
        tbl[2]  = '{8'h0D, 0,  2,        0,  0,  0};
        tbl[3]  = '{8'h08, 0,  2,        0,  0,  0};
        tbl[4]  = '{8'h0A, 70, 2 + COLS, 70, 70, 0};
        tbl[5]  = '{8'h08, 69, 2,        1,  69, 0};
        tbl[6]  = '{8'h43, 70, 2 + COLS, 71, 69, 8'h43};
        tbl[7]  = '{8'h01, 70, 2,        0,  0,  0};
        tbl[8]  = '{8'h7F, 70, 2,        0,  0,  0};
        tbl[9]  = '{8'h7E, 71, 2,        1,  70, 8'h7E};
        tbl[10] = '{8'h20, 72, 2,        1,  71, 8'h20};
        tbl[11] = '{8'h08, 71, 2,        1,  71, 0};
        tbl[12] = '{8'h0D, 70, 2,        0,  0,  0};
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].ch);
            chk("tbl_pos", {20'd0, cursor_pos}, 32'(tbl[i].pos));
            chk("tbl_lat", 32'(last_lat), 32'(tbl[i].lat));
            chk("tbl_nw", 32'(got_q.size()), 32'(tbl[i].nw));
            if (tbl[i].nw > 0 && got_q.size() > 0)
                chk("tbl_first_write", 32'(got_q[0]), 32'(tbl[i].a0 * 256 + tbl[i].d0));
        end

        // Walk to the last cell, LF wraps to row 0 and clears it
        send(8'h0C);
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send(8'h61 + 8'(i % 26));
        chk("at_last_cell", {20'd0, cursor_pos}, 32'(CELLS - 1));
        send(8'h0A);
        chk("lf_wrap_pos", {20'd0, cursor_pos}, 32'(0));
        if (got_q.size() > 0) chk("lf_wrap_first", 32'(got_q[0]), 32'(0));

        // Printable at the last cell writes it then clears row 0
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10));
        send(8'h5A);
        chk("wrap_end_pos", {20'd0, cursor_pos}, 32'(0));
        if (got_q.size() > 1) begin
            chk("wrap_end_w0", 32'(got_q[0]), 32'((CELLS - 1) * 256 + 8'h5A));
            chk("wrap_end_w1", 32'(got_q[1]), 32'(0));
        end

        // FF held valid through its own clear: exactly one more pass
        ch_valid = 1'b1;
        ch_data  = 8'h0C;
        n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        model(8'h0C, lat);
        model(8'h0C, lat);
        @(negedge clk);
        w1 = 0; n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin
            if (ram_wren === 1'b1) w1++;
            @(negedge clk); n++;
        end
        @(negedge clk);
        ch_valid = 1'b0;
        w2 = 0; n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin
            if (ram_wren === 1'b1) w2++;
            @(negedge clk); n++;
        end
        w3 = 0;
        repeat (6) begin
            if (ram_wren === 1'b1 || ch_ready !== 1'b1) w3++;
            @(negedge clk);
        end
        chk("ff_hold_pass1", 32'(w1), 32'(CELLS));
        chk("ff_hold_pass2", 32'(w2), 32'(CELLS));
        chk("ff_hold_after", 32'(w3), 32'(0));
        chk("ff_hold_pos", {20'd0, cursor_pos}, 32'(0));

        // Reset in the middle of a row clear, with a byte offered during reset
        send(8'h48);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        ch_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_and_clear(2, 1'b1);

        // Random bytes against the screen model
        ffs = 0;
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 70)      b = 8'($urandom_range(32, 126));
            else if (n < 78) b = 8'h0A;
            else if (n < 84) b = 8'h0D;
            else if (n < 92) b = 8'h08;
            else if (n < 99 || ffs >= 2) b = 8'($urandom_range(0, 31)) & 8'h17;
            else begin b = 8'h0C; ffs++; end
            send(b);
        end
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (dut_ram[i] !== mdl_ram[i]) bad++;
        chk("ram_image", 32'(bad), 32'(0));

`ifdef CURSOR_BLINK_EN
        // Idle blinking: toggles every BLINK_DIV=4 cycles
        begin
            logic v0;
            v0 = cursor_vis;
            n = 0;
            while (cursor_vis === v0 && n < 20) begin @(negedge clk); n++; end
            for (int k = 0; k < 2; k++) begin
                v0 = cursor_vis;
                n = 0;
                while (cursor_vis === v0 && n < 20) begin @(negedge clk); n++; end
                chk("blink_half_period", 32'(n), 32'(4));
            end
        end
`else
        repeat (20) @(negedge clk);
        chk("vis_const", {31'd0, cursor_vis}, 32'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
